// File: rtl/full_jacobian_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined LANES-wide multiplier among NUM_REQ Jacobian sub-blocks.
// Optional grant/stall statistics counters are built when MULT_ARB_STATS_EN is defined.
module full_jacobian_mult_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LANES        = 9,
    parameter int WIDTH        = 27,
    parameter int MULT_LATENCY = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*LANES*WIDTH-1:0]   req_dataa,
    input  logic [NUM_REQ*LANES*WIDTH-1:0]   req_datab,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [LANES*WIDTH-1:0]           mult_dataa,
    output logic [LANES*WIDTH-1:0]           mult_datab,
    input  logic [LANES*WIDTH-1:0]           mult_result,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [LANES*WIDTH-1:0]           rsp_result,
    output logic                             busy
`ifdef MULT_ARB_STATS_EN
    ,
    input  logic                             stats_clr,
    output logic [15:0]                      issue_cnt,
    output logic [15:0]                      stall_cnt
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int VEC_W = LANES * WIDTH;

    logic [PTR_W-1:0]   ptr_reg;
    logic [PTR_W-1:0]   winner;
    logic               found;
    logic               grant_any;
    logic [PTR_W-1:0]   ptr_next;

    logic               tag_valid_reg [MULT_LATENCY];
    logic [PTR_W-1:0]   tag_id_reg    [MULT_LATENCY];
    logic [NUM_REQ-1:0] rsp_valid_reg;
    logic [VEC_W-1:0]   mult_dataa_reg;
    logic [VEC_W-1:0]   mult_datab_reg;

    // Scan from the highest offset down so the offset nearest ptr wins last.
    always_comb begin
        int idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx]) begin
                winner = idx[PTR_W-1:0];
                found  = 1'b1;
            end
        end
    end

    assign grant_any = en && !rst && found;
    assign gnt       = grant_any ? (NUM_REQ'(1) << winner) : '0;
    assign ptr_next  = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg          <= '0;
            mult_dataa_reg   <= '0;
            mult_datab_reg   <= '0;
            tag_valid_reg[0] <= 1'b0;
            tag_id_reg[0]    <= '0;
        end else if (grant_any) begin
            ptr_reg          <= ptr_next;
            mult_dataa_reg   <= req_dataa[int'(winner)*VEC_W +: VEC_W];
            mult_datab_reg   <= req_datab[int'(winner)*VEC_W +: VEC_W];
            tag_valid_reg[0] <= 1'b1;
            tag_id_reg[0]    <= winner;
        end else begin
            mult_dataa_reg   <= '0;
            mult_datab_reg   <= '0;
            tag_valid_reg[0] <= 1'b0;
            tag_id_reg[0]    <= '0;
        end
    end

    // The multiplier is free-running, so the tag pipe shifts every cycle.
    for (genvar gi = 1; gi < MULT_LATENCY; gi++) begin : g_tag_stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tag_valid_reg[gi] <= 1'b0;
                tag_id_reg[gi]    <= '0;
            end else begin
                tag_valid_reg[gi] <= tag_valid_reg[gi-1];
                tag_id_reg[gi]    <= tag_id_reg[gi-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_reg <= '0;
        end else if (tag_valid_reg[MULT_LATENCY-1]) begin
            rsp_valid_reg <= NUM_REQ'(1) << tag_id_reg[MULT_LATENCY-1];
        end else begin
            rsp_valid_reg <= '0;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < MULT_LATENCY; s++) begin
            busy = busy | tag_valid_reg[s];
        end
    end

    assign mult_dataa = mult_dataa_reg;
    assign mult_datab = mult_datab_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_result = mult_result;

`ifdef MULT_ARB_STATS_EN
    logic [15:0] issue_cnt_reg;
    logic [15:0] stall_cnt_reg;
    logic        stall_hit;

    // A stall is any cycle where some requester is left waiting.
    assign stall_hit = ((|req) && !grant_any) || (grant_any && (|(req & ~gnt)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt_reg <= '0;
            stall_cnt_reg <= '0;
        end else if (stats_clr) begin
            issue_cnt_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (grant_any && issue_cnt_reg != 16'hFFFF) begin
                issue_cnt_reg <= issue_cnt_reg + 16'd1;
            end
            if (stall_hit && stall_cnt_reg != 16'hFFFF) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
        end
    end

    assign issue_cnt = issue_cnt_reg;
    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_full_jacobian_mult_arbiter.sv
// Self-checking bench: directed scenarios plus randomized requesters against a transaction-level model.
module tb_full_jacobian_mult_arbiter;

    localparam int N  = 4;
    localparam int LN = 9;
    localparam int W  = 27;
    localparam int L  = 4;
    localparam int VW = LN * W;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [N-1:0]      req;
    logic [N*VW-1:0]   req_dataa;
    logic [N*VW-1:0]   req_datab;
    logic [N-1:0]      gnt;
    logic [VW-1:0]     mult_dataa;
    logic [VW-1:0]     mult_datab;
    logic [VW-1:0]     mult_result;
    logic [N-1:0]      rsp_valid;
    logic [VW-1:0]     rsp_result;
    logic              busy;
`ifdef MULT_ARB_STATS_EN
    logic              stats_clr;
    logic [15:0]       issue_cnt;
    logic [15:0]       stall_cnt;
    int                m_issue;
    int                m_stall;
`endif

    full_jacobian_mult_arbiter #(.NUM_REQ(N), .LANES(LN), .WIDTH(W), .MULT_LATENCY(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (req),
        .req_dataa  (req_dataa),
        .req_datab  (req_datab),
        .gnt        (gnt),
        .mult_dataa (mult_dataa),
        .mult_datab (mult_datab),
        .mult_result(mult_result),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .busy       (busy)
`ifdef MULT_ARB_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .issue_cnt  (issue_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        int            id;
        logic [VW-1:0] prod;
    } rec_t;

    int            n_vec = 0;
    int            n_err = 0;
    int            cyc   = 0;
    int            m_ptr;
    logic [VW-1:0] exp_ma;
    logic [VW-1:0] exp_mb;
    rec_t          pend[$];
    logic [VW-1:0] mpipe [0:L];
    logic [VW-1:0] da_arr [N];
    logic [VW-1:0] db_arr [N];

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] lane_mul(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0]   r;
        longint unsigned p;
        r = '0;
        for (int l = 0; l < LN; l++) begin
            p = longint'(a[l*W +: W]) * longint'(b[l*W +: W]);
            r[l*W +: W] = p[W-1:0];
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        logic [31:0]   t;
        for (int l = 0; l < LN; l++) begin
            t = $urandom();
            v[l*W +: W] = t[W-1:0];
        end
        return v;
    endfunction

    // Behavioural multiplier: product of the operands shown L cycles earlier.
    task automatic shift_mult();
        for (int i = L; i > 0; i--) mpipe[i] = mpipe[i-1];
        mpipe[0]    = lane_mul(mult_dataa, mult_datab);
        mult_result = mpipe[L];
    endtask

    task automatic do_cycle(input logic en_i, input logic [N-1:0] req_i, input logic clr_i, output int win);
        logic [N-1:0]  exp_rv;
        logic [N-1:0]  exp_g;
        logic [VW-1:0] exp_rp;
        logic          have;
        logic          exp_busy;
        rec_t          r;
        int            idx;
        @(negedge clk);
        exp_rv = '0;
        exp_rp = '0;
        have   = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            exp_rv[r.id] = 1'b1;
            exp_rp = r.prod;
            have   = 1'b1;
        end
        exp_busy = 1'b0;
        foreach (pend[i]) if (pend[i].due - L <= cyc) exp_busy = 1'b1;
        check_val("rsp_valid", 256'(rsp_valid), 256'(exp_rv));
        check_val("busy", 256'(busy), 256'(exp_busy));
        check_val("mult_dataa", 256'(mult_dataa), 256'(exp_ma));
        check_val("mult_datab", 256'(mult_datab), 256'(exp_mb));
`ifdef MULT_ARB_STATS_EN
        check_val("issue_cnt", 256'(issue_cnt), 256'(m_issue));
        check_val("stall_cnt", 256'(stall_cnt), 256'(m_stall));
        stats_clr = clr_i;
`endif
        shift_mult();
        en  = en_i;
        req = req_i;
        for (int k = 0; k < N; k++) begin
            req_dataa[k*VW +: VW] = da_arr[k];
            req_datab[k*VW +: VW] = db_arr[k];
        end
        #1;
        if (have) check_val("rsp_result", 256'(rsp_result), 256'(exp_rp));
        win = -1;
        if (en_i) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (req_i[idx] && win < 0) win = idx;
            end
        end
        exp_g = (win >= 0) ? N'(1) << win : '0;
        check_val("gnt", 256'(gnt), 256'(exp_g));
        if (win >= 0) begin
            exp_ma = da_arr[win];
            exp_mb = db_arr[win];
            m_ptr  = (win + 1) % N;
            pend.push_back('{cyc + 1 + L, win, lane_mul(da_arr[win], db_arr[win])});
        end else begin
            exp_ma = '0;
            exp_mb = '0;
        end
`ifdef MULT_ARB_STATS_EN
        if (clr_i) begin
            m_issue = 0;
            m_stall = 0;
        end else begin
            if (win >= 0 && m_issue < 65535) m_issue++;
            if (req_i != 0 && (win < 0 || (req_i & ~exp_g) != 0) && m_stall < 65535) m_stall++;
        end
`endif
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        req = '1;
        #1;
        check_val("rst_gnt", 256'(gnt), 256'(0));
        check_val("rst_busy", 256'(busy), 256'(0));
        check_val("rst_rsp_valid", 256'(rsp_valid), 256'(0));
        check_val("rst_mult_dataa", 256'(mult_dataa), 256'(0));
`ifdef MULT_ARB_STATS_EN
        check_val("rst_issue_cnt", 256'(issue_cnt), 256'(0));
        check_val("rst_stall_cnt", 256'(stall_cnt), 256'(0));
        m_issue = 0;
        m_stall = 0;
`endif
        shift_mult();
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        req = '0;
        shift_mult();
        cyc++;
        m_ptr  = 0;
        exp_ma = '0;
        exp_mb = '0;
        pend.delete();
    endtask

    task automatic idle(input int n);
        int w;
        for (int i = 0; i < n; i++) do_cycle(1'b1, '0, 1'b0, w);
    endtask

    task automatic rand_ops();
        for (int k = 0; k < N; k++) begin
            da_arr[k] = rand_vec();
            db_arr[k] = rand_vec();
        end
    endtask

    initial begin
        int           w;
        logic [N-1:0] cur;
        rst         = 1'b1;
        en          = 1'b0;
        req         = '0;
        req_dataa   = '0;
        req_datab   = '0;
        mult_result = '0;
`ifdef MULT_ARB_STATS_EN
        stats_clr   = 1'b0;
        m_issue     = 0;
        m_stall     = 0;
`endif
        for (int i = 0; i <= L; i++) mpipe[i] = '0;
        for (int k = 0; k < N; k++) begin
            da_arr[k] = '0;
            db_arr[k] = '0;
        end
        do_reset();

        // Single request: lane0 3*5 returns after the full latency.
        da_arr[1][W-1:0] = 27'd3;
        db_arr[1][W-1:0] = 27'd5;
        do_cycle(1'b1, 4'b0010, 1'b0, w);
        idle(L + 2);

        // Round robin with all four requesting.
        for (int i = 0; i < 5; i++) begin
            rand_ops();
            do_cycle(1'b1, 4'b1111, 1'b0, w);
        end
        idle(2);

        // Pointer skip: move ptr to 2, then 0011 must grant 0 then 1.
        do_cycle(1'b1, 4'b0010, 1'b0, w);
        rand_ops();
        do_cycle(1'b1, 4'b0011, 1'b0, w);
        do_cycle(1'b1, 4'b0010, 1'b0, w);
        idle(2);

        // en gating with an op in flight.
        rand_ops();
        do_cycle(1'b1, 4'b0001, 1'b0, w);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 4'b0100, 1'b0, w);
        do_cycle(1'b1, 4'b0100, 1'b0, w);
        idle(L + 2);

        // Reset mid-flight discards in-flight tags.
        do_reset();
        rand_ops();
        do_cycle(1'b1, 4'b0011, 1'b0, w);
        do_cycle(1'b1, 4'b0010, 1'b0, w);
        idle(2);
        do_reset();
        idle(L + 2);

        // Two requesters held for four cycles, then a statistics clear.
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 4'b0011, 1'b0, w);
        do_cycle(1'b1, 4'b0000, 1'b1, w);
        idle(L + 2);

        // Randomized requesters obeying the hold-until-granted rule.
        cur = '0;
        for (int c = 0; c < 400; c++) begin
            rand_ops();
            for (int k = 0; k < N; k++) begin
                if (!cur[k] && $urandom_range(0, 2) == 0) cur[k] = 1'b1;
            end
            do_cycle($urandom_range(0, 9) != 0, cur, $urandom_range(0, 49) == 0, w);
            if (w >= 0) cur[w] = 1'($urandom_range(0, 1));
        end
        idle(L + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
